// File: rtl/muldiv_pkg.sv
// RV32M multiply/divide shared definitions: widths, funct3 codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement negate when n is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide, sign fix at the end.
// Latency: 33 cycles from accepted start to done; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: start is only sampled in IDLE (busy=0); starts while busy are dropped, flush aborts.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rdIn,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rdOut,
  output logic            wbEn
);

  state_e          state_q;
  logic [5:0]      cnt_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            negp_q;   // sign of product / quotient
  logic            negr_q;   // sign of remainder
  // Multiply: full 64-bit accumulator (upper partial sum, lower multiplier bits shifting out).
  // Divide: [63:32] partial remainder, [31:0] dividend bits shifting out / quotient bits in.
  logic [63:0]     acc_q;
  logic [XLEN-1:0] b_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rdout_q;
  logic            wben_q;

  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, sgn_ovf;
  logic            is_div;
  logic [32:0]     op1, op2, sum;
  logic [63:0]     acc_d;
  logic [63:0]     prod;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] fix_res_d;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign rdOut  = rdout_q;
  assign wbEn   = wben_q;

  // Decode the incoming request: operand signs, magnitudes and the early-out special cases.
  always_comb begin
    sgn_a    = opA[XLEN-1] & (funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sgn_b    = opB[XLEN-1] & (funct3 inside {F3_MULH, F3_DIV, F3_REM});
    mag_a    = cond_neg(opA, sgn_a);
    mag_b    = cond_neg(opB, sgn_b);
    div_zero = funct3[2] && (opB == '0);
    sgn_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (opA == 32'h8000_0000) && (opB == 32'hFFFF_FFFF);
  end

  // One iteration step sharing a single 33-bit adder: add for multiply, trial-subtract for divide.
  always_comb begin
    is_div = f3_q[2];
    op1    = is_div ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    op2    = is_div ? ~{1'b0, b_q} : {1'b0, b_q};
    sum    = op1 + op2 + {32'd0, is_div};
    if (is_div) begin
      // sum[32] set means the trial subtraction went negative: restore and shift in 0.
      acc_d = {(sum[32] ? acc_q[62:31] : sum[31:0]), acc_q[30:0], ~sum[32]};
    end else if (acc_q[0]) begin
      acc_d = {sum, acc_q[31:1]};
    end else begin
      acc_d = {1'b0, acc_q[63:1]};
    end
  end

  // Sign correction and result selection used in the FIX cycle.
  always_comb begin
    prod = negp_q ? (~acc_q + 64'd1) : acc_q;
    quo  = cond_neg(acc_q[31:0], negp_q);
    rem  = cond_neg(acc_q[63:32], negr_q);
    case (f3_q)
      F3_MUL:                      fix_res_d = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_d = prod[63:32];
      F3_DIV, F3_DIVU:             fix_res_d = quo;
      default:                     fix_res_d = rem;
    endcase
  end

  // Control FSM with registered outputs; flush overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      acc_q    <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rdout_q  <= '0;
      wben_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wben_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              f3_q   <= funct3;
              rd_q   <= rdIn;
              cnt_q  <= '0;
              b_q    <= mag_b;
              busy_q <= 1'b1;
              if (div_zero) begin
                acc_q   <= {opA, 32'hFFFF_FFFF};
                negp_q  <= 1'b0;
                negr_q  <= 1'b0;
                state_q <= FIX;
              end else if (sgn_ovf) begin
                acc_q   <= {32'h0000_0000, 32'h8000_0000};
                negp_q  <= 1'b0;
                negr_q  <= 1'b0;
                state_q <= FIX;
              end else begin
                acc_q   <= {32'h0000_0000, mag_a};
                negp_q  <= sgn_a ^ sgn_b;
                negr_q  <= sgn_a;
                state_q <= CALC;
              end
            end
          end
          CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == 6'(ITER - 1)) state_q <= FIX;
          end
          FIX: begin
            result_q <= fix_res_d;
            rdout_q  <= rd_q;
            done_q   <= 1'b1;
            wben_q   <= (rd_q != 5'd0);
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of RV32M ops plus flush / reset sequences.
// Latency: checks 33-cycle and 1-cycle done timing relative to the sampling edge.
// Backpressure: exercises start-while-busy, flush abort and back-to-back starts.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic [4:0]  rdIn;
  logic        flush;
  logic        busy, done, wbEn;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .rdIn(rdIn), .flush(flush),
    .busy(busy), .done(done), .result(result), .rdOut(rdOut), .wbEn(wbEn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one op starting on the next negedge and check timing and outputs.
  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; funct3 = f3; opA = a; opB = b; rdIn = rd;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, " busy@E0"}, {31'd0, busy}, 32'd1);
    chk({nm, " done@E0"}, {31'd0, done}, 32'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " result"}, result, exp_res);
    chk({nm, " rdOut"}, {27'd0, rdOut}, {27'd0, rd});
    chk({nm, " wbEn"}, {31'd0, wbEn}, {31'd0, (rd != 5'd0)});
    chk({nm, " busy@done"}, {31'd0, busy}, 32'd0);
    last_res = exp_res;
    last_rd  = rd;
  endtask

  initial begin
    int seen;
    vecs[0]  = '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 33};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 33};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 33};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 33};
    vecs[6]  = '{F3_DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        33};
    vecs[7]  = '{F3_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         33};
    vecs[8]  = '{F3_DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{F3_REM,    32'd5,          32'd0,         5'd14, 32'd5,         1};
    vecs[10] = '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1};
    vecs[11] = '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1};
    vecs[12] = '{F3_DIV,    32'd7,          32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFD, 33};
    vecs[13] = '{F3_REM,    32'd7,          32'hFFFF_FFFE, 5'd18, 32'd1,         33};
    vecs[14] = '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd19, 32'h4000_0000, 33};
    vecs[15] = '{F3_MULHSU, 32'd2,          32'h8000_0000, 5'd20, 32'd1,         33};
    vecs[16] = '{F3_DIVU,   32'hFFFF_FFFF,  32'd1,         5'd21, 32'hFFFF_FFFF, 33};
    vecs[17] = '{F3_REMU,   32'd9,          32'd0,         5'd22, 32'd9,         1};

    rst = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = '0; opA = '0; opB = '0; rdIn = '0;
    last_res = '0; last_rd = '0;

    // Reset state.
    #12;
    chk("reset busy",   {31'd0, busy}, 32'd0);
    chk("reset done",   {31'd0, done}, 32'd0);
    chk("reset wbEn",   {31'd0, wbEn}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rdOut",  {27'd0, rdOut}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table, issued back to back (each start lands in the done cycle of the previous op).
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].res, vecs[i].lat);
    end

    // Flush mid-DIV, with an ignored start while busy.
    @(negedge clk);
    start = 1'b1; funct3 = F3_DIV; opA = 32'd100; opB = 32'd7; rdIn = 5'd3;
    @(posedge clk);                 // E0
    #1 start = 1'b0;
    repeat (8) @(posedge clk);      // E8
    #1 start = 1'b1; funct3 = F3_MUL; opA = 32'd1; opB = 32'd1; rdIn = 5'd4;
    @(posedge clk);                 // E9: start while busy
    #1 start = 1'b0;
    @(posedge clk);                 // E10
    #1 flush = 1'b1;
    @(posedge clk);                 // E11: flush sampled
    #1 flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    chk("flush no done", seen, 0);
    chk("flush result kept", result, last_res);
    chk("flush rdOut kept", {27'd0, rdOut}, {27'd0, last_rd});
    run_op("after flush", F3_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);

    // flush and start in the same IDLE cycle: start dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = F3_MUL; opA = 32'd2; opB = 32'd3; rdIn = 5'd2;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    chk("flush+start busy", {31'd0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1;
    end
    chk("flush+start no done", seen, 0);

    // Asynchronous reset in the middle of a MUL.
    @(negedge clk);
    start = 1'b1; funct3 = F3_MUL; opA = 32'd3; opB = 32'd5; rdIn = 5'd9;
    @(posedge clk);                 // E0
    #1 start = 1'b0;
    repeat (15) @(posedge clk);     // E15
    #3 rst = 1'b0;
    #1;
    chk("midreset busy",   {31'd0, busy}, 32'd0);
    chk("midreset done",   {31'd0, done}, 32'd0);
    chk("midreset wbEn",   {31'd0, wbEn}, 32'd0);
    chk("midreset result", result, 32'd0);
    chk("midreset rdOut",  {27'd0, rdOut}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // rd = x0: done fires but no write-back.
    run_op("rd0 mul", F3_MUL, 32'd3, 32'd4, 5'd0, 32'd12, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
